// File: rtl/spmm_pkg.sv
// Shared definitions for the sparse row scheduler, its datapath and the bench.
//   state_t    : scheduler FSM state encoding
//   ROW_AW_DEF : default row-index width
//   NZ_AW_DEF  : default nonzero-memory address width
//   ptr_t      : CSR row_ptr value at default widths (NZ_AW_DEF+1 bits)
//   row_cnt_t  : row count at default widths (ROW_AW_DEF+1 bits)
package spmm_pkg;

   localparam int unsigned ROW_AW_DEF = 6;
   localparam int unsigned NZ_AW_DEF  = 10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD0,
      S_LD0_W,
      S_LDN,
      S_LDN_W,
      S_ISSUE,
      S_ROW_END,
      S_FIN
   } state_t;

   typedef logic [NZ_AW_DEF:0]  ptr_t;
   typedef logic [ROW_AW_DEF:0] row_cnt_t;

endpackage

// File: rtl/spmm_row_sched_if.sv
// Memory-side bus of the row scheduler.
//   ptr_rd/ptr_addr/ptr_data : row-pointer memory read port (data 1 cycle after rd)
//   nz_valid/nz_addr/nz_ready: nonzero address handshake to the multiplier
// master = scheduler, slave = memory / datapath.
interface spmm_row_sched_if
   import spmm_pkg::*;
#(
   parameter int unsigned ROW_AW = ROW_AW_DEF,
   parameter int unsigned NZ_AW  = NZ_AW_DEF
) ();

   logic              ptr_rd;
   logic [ROW_AW:0]   ptr_addr;
   logic [NZ_AW:0]    ptr_data;
   logic              nz_valid;
   logic [NZ_AW-1:0]  nz_addr;
   logic              nz_ready;

   modport master (
      output ptr_rd, ptr_addr, nz_valid, nz_addr,
      input  ptr_data, nz_ready
   );

   modport slave (
      input  ptr_rd, ptr_addr, nz_valid, nz_addr,
      output ptr_data, nz_ready
   );

endinterface

// File: rtl/spmm_row_sched.sv
// CSR sparse-matrix row scheduler. Walks row_ptr, issues one nonzero address
// per accepted handshake, and frames each row with acc_clr / row_done.
//   clk, rst        : clock, synchronous active-high reset
//   start, num_rows : matrix request (num_rows sampled only when idle)
//   bus (master)    : row-pointer read port and nonzero address handshake
//   acc_clr         : accumulator clear, one cycle before each row
//   row_done/row_idx/row_empty : per-row completion
//   busy, done      : matrix in progress / one-cycle completion pulse
//   err             : sticky malformed-pointer flag, cleared by next start
module spmm_row_sched
   import spmm_pkg::*;
#(
   parameter int unsigned ROW_AW = ROW_AW_DEF,
   parameter int unsigned NZ_AW  = NZ_AW_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ROW_AW:0]      num_rows,
   spmm_row_sched_if.master     bus,
   output logic                 acc_clr,
   output logic                 row_done,
   output logic [ROW_AW-1:0]    row_idx,
   output logic                 row_empty,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   typedef logic [NZ_AW:0]  nzp_t;
   typedef logic [ROW_AW:0] rcnt_t;

   state_t state, state_nx;
   rcnt_t  r;
   rcnt_t  nrows_q;
   nzp_t   cur_ptr;
   nzp_t   end_ptr;
   logic   empty_q;
   logic   last_row;

   logic              ptr_rd_c;
   logic [ROW_AW:0]   ptr_addr_c;
   logic              nz_valid_c;
   logic [NZ_AW-1:0]  nz_addr_c;

   assign last_row = ((r + rcnt_t'(1)) == nrows_q);
   assign busy     = (state != S_IDLE);

   assign bus.ptr_rd   = ptr_rd_c;
   assign bus.ptr_addr = ptr_addr_c;
   assign bus.nz_valid = nz_valid_c;
   assign bus.nz_addr  = nz_addr_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         r       <= '0;
         nrows_q <= '0;
         cur_ptr <= '0;
         end_ptr <= '0;
         empty_q <= 1'b0;
         err     <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: begin
               if (start) begin
                  nrows_q <= num_rows;
                  r       <= '0;
                  err     <= 1'b0;
               end
            end
            S_LD0_W: cur_ptr <= bus.ptr_data;
            S_LDN_W: begin
               end_ptr <= bus.ptr_data;
               empty_q <= (bus.ptr_data <= cur_ptr);
               if (bus.ptr_data < cur_ptr) err <= 1'b1;
            end
            S_ISSUE: begin
               if (bus.nz_ready) cur_ptr <= cur_ptr + nzp_t'(1);
            end
            S_ROW_END: begin
               // Resync to end_ptr so a malformed (decreasing) row restarts cleanly.
               cur_ptr <= end_ptr;
               if (!last_row) r <= r + rcnt_t'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx   = state;
      ptr_rd_c   = 1'b0;
      ptr_addr_c = '0;
      nz_valid_c = 1'b0;
      nz_addr_c  = '0;
      acc_clr    = 1'b0;
      row_done   = 1'b0;
      row_idx    = '0;
      row_empty  = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nx = (num_rows == '0) ? S_FIN : S_LD0;
         end
         S_LD0: begin
            ptr_rd_c = 1'b1;
            state_nx = S_LD0_W;
         end
         S_LD0_W: state_nx = S_LDN;
         S_LDN: begin
            ptr_rd_c   = 1'b1;
            ptr_addr_c = r + rcnt_t'(1);
            state_nx   = S_LDN_W;
         end
         S_LDN_W: begin
            acc_clr  = 1'b1;
            // end_ptr is still on ptr_data here, not yet registered.
            state_nx = (bus.ptr_data > cur_ptr) ? S_ISSUE : S_ROW_END;
         end
         S_ISSUE: begin
            nz_valid_c = 1'b1;
            nz_addr_c  = cur_ptr[NZ_AW-1:0];
            if (bus.nz_ready && ((cur_ptr + nzp_t'(1)) == end_ptr)) state_nx = S_ROW_END;
         end
         S_ROW_END: begin
            row_done  = 1'b1;
            row_idx   = r[ROW_AW-1:0];
            row_empty = empty_q;
            state_nx  = last_row ? S_FIN : S_LDN;
         end
         S_FIN: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule
